switch_allocator: RTL and testbench

Per-router switch allocator that produces the five 3-bit crossbar select codes (S_E, S_W, S_N, S_S, S_Ejec) from input-port flit requests. It sits between the input buffers and the crossbar, arbitrating each output port round-robin among requesting inputs. It holds an output for one input for the whole wormhole packet, from the head flit through the tail flit. Select encoding is the crossbar's own: 0=E, 1=W, 2=N, 3=S, 4=Inject; 3'd7 = idle, so the crossbar drives zero.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/sa_out_arbiter.sv | 124 ++++++++++++
 rtl/switch_allocator.sv | 60 ++++++
 tb/tb_switch_allocator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, crossbar select codes and
// the output-arbiter state type used by the switch allocator.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  // Input side: E, W, N, S, Inject. Output side: E, W, N, S, Eject.
  localparam int PORT_E   = 0;
  localparam int PORT_W   = 1;
  localparam int PORT_N   = 2;
  localparam int PORT_S   = 3;
  localparam int PORT_INJ = 4;
  localparam int PORT_EJ  = 4;

  // Crossbar select width; code 7 makes the crossbar drive zero.
  localparam int         SEL_W    = 3;
  localparam logic [2:0] SEL_IDLE = 3'd7;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sa_out_arbiter.sv
// One output port's arbiter: round-robin among candidate inputs, then holds
// the output for the winner until its tail flit crosses (wormhole lock).
// Optional SA_LOCK_TIMEOUT_EN: a lock starved of grants for TIMEOUT_CYCLES
// cycles is force-released with a one-cycle timeout_o pulse.
module sa_out_arbiter
  import noc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] cand_i,   // req & dest match & out_ready
  input  logic [NUM_PORTS-1:0] tail_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 timeout_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  st_q, st_d;
  logic [2:0]  own_q, own_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        found;
  logic [2:0]  pick;
  logic [3:0]  idx;

`ifdef SA_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Round-robin pick, lock tracking and select/grant generation.
  always_comb begin
    st_d      = st_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    sel_o     = SEL_IDLE;
    gnt_o     = '0;
    timeout_o = 1'b0;
    found     = 1'b0;
    pick      = '0;
    idx       = '0;
`ifdef SA_LOCK_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    // Search starts one past the last winner and wraps mod NUM_PORTS.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!found && cand_i[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
    case (st_q)
      ARB_IDLE: begin
        if (found) begin
          sel_o       = pick;
          gnt_o[pick] = 1'b1;
          ptr_d       = pick;
          if (!tail_i[pick]) begin
            st_d  = ARB_LOCKED;
            own_d = pick;
`ifdef SA_LOCK_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      ARB_LOCKED: begin
`ifdef SA_LOCK_TIMEOUT_EN
        if (cnt_q == TO_MAX) begin
          timeout_o = 1'b1;
          st_d      = ARB_IDLE;
        end else if (cand_i[own_q]) begin
          sel_o        = own_q;
          gnt_o[own_q] = 1'b1;
          cnt_d        = '0;
          if (tail_i[own_q]) st_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        if (cand_i[own_q]) begin
          sel_o        = own_q;
          gnt_o[own_q] = 1'b1;
          if (tail_i[own_q]) st_d = ARB_IDLE;
        end
`endif
      end
      default: st_d = ARB_IDLE;
    endcase
    // Outputs are quiet throughout reset regardless of requests.
    if (rst) begin
      sel_o     = SEL_IDLE;
      gnt_o     = '0;
      timeout_o = 1'b0;
    end
  end

  // State registers; ptr resets to 4 so the first search begins at E.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ARB_IDLE;
      own_q <= '0;
      ptr_q <= 3'd4;
`ifdef SA_LOCK_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
`ifdef SA_LOCK_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-router switch allocator: zero-cycle crossbar selects and input grants.
// One sa_out_arbiter per output port. Optional SA_LOCK_TIMEOUT_EN enables
// forced release of starved wormhole locks (lock_timeout pulses).
module switch_allocator
  import noc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [3*NUM_PORTS-1:0] dest,
  input  logic [NUM_PORTS-1:0]   tail,
  input  logic [NUM_PORTS-1:0]   out_ready,
  output logic [SEL_W-1:0]       S_E,
  output logic [SEL_W-1:0]       S_W,
  output logic [SEL_W-1:0]       S_N,
  output logic [SEL_W-1:0]       S_S,
  output logic [SEL_W-1:0]       S_Ejec,
  output logic [NUM_PORTS-1:0]   grant,
  output logic [NUM_PORTS-1:0]   lock_timeout
);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand;   // [output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_m;  // [output][input]
  logic [NUM_PORTS-1:0][SEL_W-1:0]     sel;

  // Candidate mask per output; invalid dest codes 5..7 match no output.
  always_comb begin
    cand = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        cand[o][i] = req[i] && (dest[3*i +: 3] == 3'(o)) && out_ready[o];
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    sa_out_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .cand_i    (cand[o]),
      .tail_i    (tail),
      .sel_o     (sel[o]),
      .gnt_o     (gnt_m[o]),
      .timeout_o (lock_timeout[o])
    );
  end

  // Each input targets one output, so OR-ing per-output grants is exact.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) grant = grant | gnt_m[o];
  end

  assign S_E    = sel[PORT_E];
  assign S_W    = sel[PORT_W];
  assign S_N    = sel[PORT_N];
  assign S_S    = sel[PORT_S];
  assign S_Ejec = sel[PORT_EJ];

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed vectors with literal expectations plus
// a per-cycle behavioural model of the allocation rules.
module tb_switch_allocator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req, tail, out_ready;
  logic [14:0] dest;
  logic [2:0]  S_E, S_W, S_N, S_S, S_Ejec;
  logic [4:0]  grant, lock_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  switch_allocator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .dest(dest), .tail(tail),
    .out_ready(out_ready), .S_E(S_E), .S_W(S_W), .S_N(S_N), .S_S(S_S),
    .S_Ejec(S_Ejec), .grant(grant), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_lock[5] = '{0, 0, 0, 0, 0};
  int m_own [5] = '{0, 0, 0, 0, 0};
  int m_ptr [5] = '{4, 4, 4, 4, 4};
  int m_cnt [5] = '{0, 0, 0, 0, 0};
  int n_lock[5], n_own[5], n_ptr[5], n_cnt[5];

  // Evaluate the rules for the current inputs, compare, stage next state.
  always @(negedge clk) begin
    int esel[5];
    int eg, eto;
    eg = 0; eto = 0;
    for (int o = 0; o < 5; o++) begin
      esel[o] = 7;
      n_lock[o] = m_lock[o]; n_own[o] = m_own[o];
      n_ptr[o]  = m_ptr[o];  n_cnt[o] = m_cnt[o];
    end
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        n_lock[o] = 0; n_own[o] = 0; n_ptr[o] = 4; n_cnt[o] = 0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        int order[$];
        bit own_in;
        order = {};
        for (int k = 1; k <= 5; k++) begin
          int i;
          i = (m_ptr[o] + k) % 5;
          if (req[i] && int'(dest[3*i +: 3]) == o && out_ready[o]) order.push_back(i);
        end
        if (m_lock[o] != 0) begin
          own_in = 0;
          foreach (order[q]) if (order[q] == m_own[o]) own_in = 1;
`ifdef SA_LOCK_TIMEOUT_EN
          if (m_cnt[o] == TO) begin
            eto |= (1 << o);
            n_lock[o] = 0;
          end else
`endif
          if (own_in) begin
            esel[o] = m_own[o];
            eg |= (1 << m_own[o]);
            n_cnt[o] = 0;
            if (tail[m_own[o]]) n_lock[o] = 0;
          end else begin
            n_cnt[o] = m_cnt[o] + 1;
          end
        end else if (order.size() > 0) begin
          esel[o] = order[0];
          eg |= (1 << order[0]);
          n_ptr[o] = order[0];
          if (!tail[order[0]]) begin
            n_lock[o] = 1; n_own[o] = order[0]; n_cnt[o] = 0;
          end
        end
      end
    end
    chk("model S_E", int'(S_E), esel[0]);
    chk("model S_W", int'(S_W), esel[1]);
    chk("model S_N", int'(S_N), esel[2]);
    chk("model S_S", int'(S_S), esel[3]);
    chk("model S_Ejec", int'(S_Ejec), esel[4]);
    chk("model grant", int'(grant), eg);
    chk("model lock_timeout", int'(lock_timeout), eto);
  end

  always @(posedge clk) begin
    for (int o = 0; o < 5; o++) begin
      m_lock[o] = n_lock[o]; m_own[o] = n_own[o];
      m_ptr[o]  = n_ptr[o];  m_cnt[o] = n_cnt[o];
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [14:0] dst(input int e, input int w, input int n,
                                      input int s, input int j);
    return {3'(j), 3'(s), 3'(n), 3'(w), 3'(e)};
  endfunction

  // Apply one cycle of inputs just after the edge; settle before checking.
  task automatic step(input logic r, input logic [4:0] rq, input logic [14:0] d,
                      input logic [4:0] t, input logic [4:0] rdy);
    @(posedge clk); #1;
    rst = r; req = rq; dest = d; tail = t; out_ready = rdy;
    #1;
  endtask

  localparam logic [4:0] ALL = 5'b11111;

  initial begin
    int exp_to, exp_sw, exp_g;
    rst = 1'b1; req = '0; dest = '0; tail = '0; out_ready = ALL;

    // Reset gates outputs even with a live request.
    step(1, 5'b00100, dst(0, 0, 0, 0, 0), 5'b00100, ALL);
    chk("reset S_E", int'(S_E), 7);
    chk("reset grant", int'(grant), 0);
    step(0, 5'b00000, dst(0, 0, 0, 0, 0), 5'b00000, ALL);
    chk("idle S_E", int'(S_E), 7);
    chk("idle S_Ejec", int'(S_Ejec), 7);
    chk("idle grant", int'(grant), 0);

    // First request N->E, single flit.
    step(0, 5'b00100, dst(0, 0, 0, 0, 0), 5'b00100, ALL);
    chk("N->E S_E", int'(S_E), 2);
    chk("N->E grant", int'(grant), 5'b00100);

    // E, W, S contend for Eject with single-flit packets.
    step(0, 5'b01011, dst(4, 4, 0, 4, 0), 5'b01011, ALL);
    chk("rr1 S_Ejec", int'(S_Ejec), 0);
    chk("rr1 grant", int'(grant), 5'b00001);
    step(0, 5'b01011, dst(4, 4, 0, 4, 0), 5'b01011, ALL);
    chk("rr2 S_Ejec", int'(S_Ejec), 1);
    chk("rr2 grant", int'(grant), 5'b00010);
    step(0, 5'b01011, dst(4, 4, 0, 4, 0), 5'b01011, ALL);
    chk("rr3 S_Ejec", int'(S_Ejec), 3);
    chk("rr3 grant", int'(grant), 5'b01000);

    // W 3-flit packet to N while S also wants N.
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01000, ALL);
    chk("pkt1 S_N", int'(S_N), 1);
    chk("pkt1 grant", int'(grant), 5'b00010);
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01000, ALL);
    chk("pkt2 S_N", int'(S_N), 1);
    chk("pkt2 grant", int'(grant), 5'b00010);
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01010, ALL);
    chk("pkt3 S_N", int'(S_N), 1);
    chk("pkt3 grant", int'(grant), 5'b00010);
    step(0, 5'b01000, dst(0, 0, 0, 2, 0), 5'b01000, ALL);
    chk("after tail S_N", int'(S_N), 3);
    chk("after tail grant", int'(grant), 5'b01000);

    // Locked W->N with out_ready[N] dropped for two cycles.
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01000, ALL);
    chk("relock S_N", int'(S_N), 1);
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01000, 5'b11011);
    chk("stall1 S_N", int'(S_N), 7);
    chk("stall1 grant", int'(grant), 0);
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01000, 5'b11011);
    chk("stall2 S_N", int'(S_N), 7);
    chk("stall2 grant", int'(grant), 0);
    step(0, 5'b01010, dst(0, 2, 0, 2, 0), 5'b01010, ALL);
    chk("resume S_N", int'(S_N), 1);
    chk("resume grant", int'(grant), 5'b00010);
    step(0, 5'b01000, dst(0, 0, 0, 2, 0), 5'b01000, ALL);
    chk("S wins N", int'(S_N), 3);

    // Two outputs in the same cycle.
    step(0, 5'b10100, dst(0, 0, 3, 0, 0), 5'b10100, ALL);
    chk("dual S_E", int'(S_E), 4);
    chk("dual S_S", int'(S_S), 2);
    chk("dual grant", int'(grant), 5'b10100);

    // Invalid destinations are never granted.
    step(0, 5'b00110, dst(0, 5, 7, 0, 0), 5'b00110, ALL);
    chk("invalid grant", int'(grant), 0);
    chk("invalid S_W", int'(S_W), 7);

    // Lock E->W with a head flit, then starve it.
    step(0, 5'b00001, dst(1, 0, 0, 0, 0), 5'b00000, ALL);
    chk("head S_W", int'(S_W), 0);
    chk("head grant", int'(grant), 5'b00001);
    for (int c = 0; c < TO; c++) begin
      step(0, 5'b00000, dst(0, 0, 0, 0, 0), 5'b00000, ALL);
      chk("starve lock_timeout", int'(lock_timeout), 0);
      chk("starve S_W", int'(S_W), 7);
    end
`ifdef SA_LOCK_TIMEOUT_EN
    exp_to = 5'b00010; exp_sw = 2; exp_g = 5'b00100;
`else
    exp_to = 0; exp_sw = 7; exp_g = 0;
`endif
    step(0, 5'b00000, dst(0, 0, 0, 0, 0), 5'b00000, ALL);
    chk("timeout pulse", int'(lock_timeout), exp_to);
    step(0, 5'b00100, dst(0, 0, 1, 0, 0), 5'b00100, ALL);
    chk("post-timeout S_W", int'(S_W), exp_sw);
    chk("post-timeout grant", int'(grant), exp_g);
    chk("post-timeout pulse gone", int'(lock_timeout), 0);

    // Reset mid-packet drops the lock: W->N head then reset, S->N next.
    step(0, 5'b00010, dst(0, 2, 0, 0, 0), 5'b00000, ALL);
    step(1, 5'b00000, dst(0, 0, 0, 0, 0), 5'b00000, ALL);
    step(0, 5'b01000, dst(0, 0, 0, 2, 0), 5'b01000, ALL);
    chk("reset drop S_N", int'(S_N), 3);

    step(0, 5'b00000, dst(0, 0, 0, 0, 0), 5'b00000, ALL);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
